// File: rtl/add_arbiter_pkg.sv
// Shared constants for the add/subtract datapath arbiter: FSM encoding, requester ids and width.
package add_arbiter_pkg;

    localparam int unsigned WIDTH = 32;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] EXEC = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    localparam logic REQ0 = 1'b0;
    localparam logic REQ1 = 1'b1;

endpackage

// File: rtl/add_arbiter_if.sv
// Request, adder and response signal bundle for add_arbiter.
// master = requesters plus adder side, slave = the arbiter.
interface add_arbiter_if #(
    parameter int unsigned WIDTH = add_arbiter_pkg::WIDTH
) ();

    logic             req_valid_0;
    logic             req_ready_0;
    logic [WIDTH-1:0] req_A_0;
    logic [WIDTH-1:0] req_B_0;
    logic             req_sub_0;

    logic             req_valid_1;
    logic             req_ready_1;
    logic [WIDTH-1:0] req_A_1;
    logic [WIDTH-1:0] req_B_1;
    logic             req_sub_1;

    logic [WIDTH-1:0] adder_A;
    logic [WIDTH-1:0] adder_B;
    logic             adder_cin;
    logic [WIDTH-1:0] adder_result;
    logic             adder_overflow;
    logic             adder_isNotEqual;

    logic             rsp_valid_0;
    logic             rsp_ready_0;
    logic             rsp_valid_1;
    logic             rsp_ready_1;
    logic [WIDTH-1:0] rsp_result;
    logic             rsp_overflow;
    logic             rsp_isNotEqual;

    modport master (
        output req_valid_0, req_A_0, req_B_0, req_sub_0,
        output req_valid_1, req_A_1, req_B_1, req_sub_1,
        input  req_ready_0, req_ready_1,
        input  adder_A, adder_B, adder_cin,
        output adder_result, adder_overflow, adder_isNotEqual,
        input  rsp_valid_0, rsp_valid_1, rsp_result, rsp_overflow, rsp_isNotEqual,
        output rsp_ready_0, rsp_ready_1
    );

    modport slave (
        input  req_valid_0, req_A_0, req_B_0, req_sub_0,
        input  req_valid_1, req_A_1, req_B_1, req_sub_1,
        output req_ready_0, req_ready_1,
        output adder_A, adder_B, adder_cin,
        input  adder_result, adder_overflow, adder_isNotEqual,
        output rsp_valid_0, rsp_valid_1, rsp_result, rsp_overflow, rsp_isNotEqual,
        input  rsp_ready_0, rsp_ready_1
    );

endinterface

// File: rtl/rr_arbiter_2.sv
// Combinational two-way round-robin pick: on a tie the requester that did not win last time wins.
module rr_arbiter_2
    import add_arbiter_pkg::*;
(
    input  logic [1:0] req_i,
    input  logic       last_grant_i,
    output logic [1:0] grant_o,
    output logic       valid_o
);

    always_comb begin
        grant_o = 2'b00;
        unique case (req_i)
            2'b01:   grant_o = 2'b01;
            2'b10:   grant_o = 2'b10;
            2'b11:   grant_o = (last_grant_i == REQ1) ? 2'b01 : 2'b10;
            default: grant_o = 2'b00;
        endcase
    end

    assign valid_o = |req_i;

endmodule

// File: rtl/add_arbiter.sv
// Two-requester round-robin sequencer for the shared add/subtract datapath (IDLE -> EXEC -> RESP).
// Optional grant counters are built when ADD_ARB_STATS_EN is defined.
module add_arbiter
    import add_arbiter_pkg::*;
#(
    parameter int unsigned WIDTH = add_arbiter_pkg::WIDTH
) (
    input  logic         clock,
    input  logic         reset,
    add_arbiter_if.slave bus
`ifdef ADD_ARB_STATS_EN
    ,
    output logic [31:0]  grant_count_0,
    output logic [31:0]  grant_count_1
`endif
);

    logic [1:0]       state_q, state_d;
    logic             last_grant_q;
    logic             gnt_id_q;
    logic [WIDTH-1:0] op_a_q, op_b_q;
    logic             op_sub_q;
    logic [WIDTH-1:0] rsp_result_q;
    logic             rsp_overflow_q;
    logic             rsp_ne_q;

    logic [1:0] grant;
    logic       grant_valid;
    logic       accept;
    logic       sel_id;
    logic       rsp_take;

    rr_arbiter_2 u_rr (
        .req_i        ({bus.req_valid_1, bus.req_valid_0}),
        .last_grant_i (last_grant_q),
        .grant_o      (grant),
        .valid_o      (grant_valid)
    );

    // Gated by reset so req_ready reads 0 while reset is held.
    assign accept   = (state_q == IDLE) && grant_valid && !reset;
    assign sel_id   = grant[1] ? REQ1 : REQ0;
    assign rsp_take = (gnt_id_q == REQ0) ? bus.rsp_ready_0 : bus.rsp_ready_1;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (grant_valid) state_d = EXEC;
            EXEC:    state_d = RESP;
            RESP:    if (rsp_take) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q        <= IDLE;
            last_grant_q   <= REQ1;
            gnt_id_q       <= REQ0;
            op_a_q         <= '0;
            op_b_q         <= '0;
            op_sub_q       <= 1'b0;
            rsp_result_q   <= '0;
            rsp_overflow_q <= 1'b0;
            rsp_ne_q       <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                gnt_id_q     <= sel_id;
                last_grant_q <= sel_id;
                op_a_q       <= (sel_id == REQ1) ? bus.req_A_1 : bus.req_A_0;
                op_b_q       <= (sel_id == REQ1) ? bus.req_B_1 : bus.req_B_0;
                op_sub_q     <= (sel_id == REQ1) ? bus.req_sub_1 : bus.req_sub_0;
            end
            if (state_q == EXEC) begin
                rsp_result_q   <= bus.adder_result;
                rsp_overflow_q <= bus.adder_overflow;
                rsp_ne_q       <= bus.adder_isNotEqual;
            end
        end
    end

    assign bus.req_ready_0 = accept && grant[0];
    assign bus.req_ready_1 = accept && grant[1];

    // Operand registers change only on accept, so the adder inputs hold outside EXEC.
    assign bus.adder_A   = op_a_q;
    assign bus.adder_B   = op_b_q;
    assign bus.adder_cin = op_sub_q;

    assign bus.rsp_valid_0    = (state_q == RESP) && (gnt_id_q == REQ0);
    assign bus.rsp_valid_1    = (state_q == RESP) && (gnt_id_q == REQ1);
    assign bus.rsp_result     = rsp_result_q;
    assign bus.rsp_overflow   = rsp_overflow_q;
    assign bus.rsp_isNotEqual = rsp_ne_q;

`ifdef ADD_ARB_STATS_EN
    logic [31:0] cnt0_q, cnt1_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt0_q <= '0;
            cnt1_q <= '0;
        end else begin
            if (accept && grant[0] && (cnt0_q != 32'hFFFF_FFFF)) cnt0_q <= cnt0_q + 32'd1;
            if (accept && grant[1] && (cnt1_q != 32'hFFFF_FFFF)) cnt1_q <= cnt1_q + 32'd1;
        end
    end

    assign grant_count_0 = cnt0_q;
    assign grant_count_1 = cnt1_q;
`endif

endmodule

// File: tb/tb_add_arbiter.sv
// Scoreboard bench for add_arbiter: stimulus pushes expected responses, a monitor pops on handshake.
module tb_add_arbiter;

    typedef struct packed {
        logic        id;
        logic [31:0] res;
        logic        ovf;
        logic        ne;
    } exp_t;

    logic clock = 1'b0;
    logic reset;
    int   checks = 0;
    int   failures = 0;
    int   w;
    exp_t sb[$];

    add_arbiter_if bus ();

`ifdef ADD_ARB_STATS_EN
    logic [31:0] gc0, gc1;
`endif

    add_arbiter dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
`ifdef ADD_ARB_STATS_EN
        ,
        .grant_count_0 (gc0),
        .grant_count_1 (gc1)
`endif
    );

    always #5 clock = ~clock;

    // Behavioural adder standing in for add_circuit.
    logic [31:0] sum;
    always_comb begin
        sum = bus.adder_cin ? (bus.adder_A - bus.adder_B) : (bus.adder_A + bus.adder_B);
    end
    assign bus.adder_result     = sum;
    assign bus.adder_overflow   = bus.adder_cin ?
        ((bus.adder_A[31] != bus.adder_B[31]) && (sum[31] != bus.adder_A[31])) :
        ((bus.adder_A[31] == bus.adder_B[31]) && (sum[31] != bus.adder_A[31]));
    assign bus.adder_isNotEqual = (bus.adder_A != bus.adder_B);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
        end
    endtask

    task automatic drive_ops(input logic id, input logic [31:0] a, input logic [31:0] b,
                             input logic sub);
        if (id) begin
            bus.req_A_1 = a; bus.req_B_1 = b; bus.req_sub_1 = sub;
        end else begin
            bus.req_A_0 = a; bus.req_B_0 = b; bus.req_sub_0 = sub;
        end
    endtask

    task automatic set_valid(input logic id, input logic v);
        if (id) bus.req_valid_1 = v;
        else    bus.req_valid_0 = v;
    endtask

    function automatic logic ready_of(input logic id);
        return id ? bus.req_ready_1 : bus.req_ready_0;
    endfunction

    task automatic push_exp(input logic id, input logic [31:0] res, input logic ovf,
                            input logic ne);
        exp_t e;
        e.id = id; e.res = res; e.ovf = ovf; e.ne = ne;
        sb.push_back(e);
    endtask

    // Presents one request, pushes its expected response at acceptance, then drops valid.
    task automatic do_req(input logic id, input logic [31:0] a, input logic [31:0] b,
                          input logic sub, input logic [31:0] res, input logic ovf,
                          input logic ne, output int waited);
        bit got = 0;
        waited = 0;
        @(posedge clock); #1;
        drive_ops(id, a, b, sub);
        set_valid(id, 1'b1);
        while (!got && waited < 50) begin
            @(negedge clock);
            if (ready_of(id)) begin
                got = 1;
                push_exp(id, res, ovf, ne);
            end else begin
                waited++;
            end
        end
        check("accept_timeout", {31'd0, got}, 32'd1);
        @(posedge clock); #1;
        set_valid(id, 1'b0);
    endtask

    task automatic wait_drain();
        int n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(negedge clock);
            n++;
        end
        check("drain", sb.size(), 32'd0);
    endtask

    // Monitor: compares every consumed response against the scoreboard head.
    initial begin
        exp_t e;
        forever begin
            @(negedge clock);
            if (bus.rsp_valid_0 && bus.rsp_valid_1) begin
                checks++;
                failures++;
                $display("FAIL rsp_onehot actual=11 required=one-hot at %0t", $time);
            end
            if ((bus.rsp_valid_0 && bus.rsp_ready_0) || (bus.rsp_valid_1 && bus.rsp_ready_1)) begin
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_rsp actual=response required=none at %0t", $time);
                end else begin
                    e = sb.pop_front();
                    check("rsp_id", {31'd0, bus.rsp_valid_1}, {31'd0, e.id});
                    check("rsp_result", bus.rsp_result, e.res);
                    check("rsp_overflow", {31'd0, bus.rsp_overflow}, {31'd0, e.ovf});
                    check("rsp_isNotEqual", {31'd0, bus.rsp_isNotEqual}, {31'd0, e.ne});
                end
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        int cyc;
        int last;
        bit seen;
        logic exp_id;

        reset = 1'b1;
        bus.req_valid_0 = 0; bus.req_valid_1 = 0;
        drive_ops(1'b0, 32'd0, 32'd0, 1'b0);
        drive_ops(1'b1, 32'd0, 32'd0, 1'b0);
        bus.rsp_ready_0 = 1; bus.rsp_ready_1 = 1;

        #12;
        check("reset_req_ready_0", {31'd0, bus.req_ready_0}, 32'd0);
        check("reset_rsp_valid_0", {31'd0, bus.rsp_valid_0}, 32'd0);
        check("reset_rsp_valid_1", {31'd0, bus.rsp_valid_1}, 32'd0);
        check("reset_adder_A", bus.adder_A, 32'd0);
        check("reset_rsp_result", bus.rsp_result, 32'd0);
`ifdef ADD_ARB_STATS_EN
        check("reset_gc0", gc0, 32'd0);
        check("reset_gc1", gc1, 32'd0);
`endif
        @(posedge clock); #1;
        reset = 1'b0;

        // Reset while an operation is in EXEC.
        @(posedge clock); #1;
        drive_ops(1'b0, 32'h55, 32'h22, 1'b0);
        bus.req_valid_0 = 1;
        @(negedge clock);
        check("t1_ready_0", {31'd0, bus.req_ready_0}, 32'd1);
        @(posedge clock); #1;
        check("t1_exec_adder_A", bus.adder_A, 32'h55);
        reset = 1'b1;
        #1;
        check("t1_async_adder_A", bus.adder_A, 32'd0);
        check("t1_async_adder_B", bus.adder_B, 32'd0);
        check("t1_async_req_ready_0", {31'd0, bus.req_ready_0}, 32'd0);
        check("t1_async_rsp_valid_0", {31'd0, bus.rsp_valid_0}, 32'd0);
`ifdef ADD_ARB_STATS_EN
        check("t1_async_gc0", gc0, 32'd0);
`endif
        bus.req_valid_0 = 0;
        @(posedge clock); #1;
        reset = 1'b0;
        seen = 0;
        repeat (5) begin
            @(negedge clock);
            if (bus.rsp_valid_0 || bus.rsp_valid_1) seen = 1;
        end
        check("t1_no_rsp_after_reset", {31'd0, seen}, 32'd0);

        // Single requester 0 add, with latency.
        do_req(1'b0, 32'd5, 32'd3, 1'b0, 32'd8, 1'b0, 1'b1, w);
        check("t2_wait", w, 32'd0);
        @(negedge clock);
        check("t2_exec_no_valid", {31'd0, bus.rsp_valid_0}, 32'd0);
        @(negedge clock);
        check("t2_rsp_valid_0", {31'd0, bus.rsp_valid_0}, 32'd1);
        wait_drain();

        // Requester 1: overflow and equality.
        do_req(1'b1, 32'h7FFF_FFFF, 32'd1, 1'b0, 32'h8000_0000, 1'b1, 1'b1, w);
        do_req(1'b1, 32'h1234_5678, 32'h1234_5678, 1'b1, 32'd0, 1'b0, 1'b0, w);
        wait_drain();

        // Back-pressure on response 0 while requester 1 waits.
        @(posedge clock); #1;
        bus.rsp_ready_0 = 0;
        do_req(1'b0, 32'd10, 32'd4, 1'b1, 32'd6, 1'b0, 1'b1, w);
        drive_ops(1'b1, 32'd1, 32'd2, 1'b0);
        bus.req_valid_1 = 1;
        @(negedge clock);
        check("t5_exec_ready_1", {31'd0, bus.req_ready_1}, 32'd0);
        repeat (5) begin
            @(negedge clock);
            check("t5_hold_valid_0", {31'd0, bus.rsp_valid_0}, 32'd1);
            check("t5_hold_result", bus.rsp_result, 32'd6);
            check("t5_hold_ready_1", {31'd0, bus.req_ready_1}, 32'd0);
        end
        @(posedge clock); #1;
        bus.rsp_ready_0 = 1;
        @(negedge clock);
        check("t5_exit_ready_1", {31'd0, bus.req_ready_1}, 32'd0);
        do_req(1'b1, 32'd1, 32'd2, 1'b0, 32'd3, 1'b0, 1'b1, w);
        check("t5_accept_after_exit", w, 32'd0);
        wait_drain();

        // Both requesters always valid: strict alternation, 3 cycles per op.
        drive_ops(1'b0, 32'd1000, 32'd1, 1'b0);
        drive_ops(1'b1, 32'd50, 32'd1, 1'b1);
        bus.req_valid_0 = 1;
        bus.req_valid_1 = 1;
        k = 0; cyc = 0; last = 0;
        while (k < 20 && cyc < 200) begin
            @(negedge clock);
            cyc++;
            if (bus.req_ready_0 || bus.req_ready_1) begin
                exp_id = k[0];
                check("t3_grant", {30'd0, bus.req_ready_1, bus.req_ready_0},
                      exp_id ? 32'd2 : 32'd1);
                if (exp_id) push_exp(1'b1, 32'd50 - k, 1'b0, 1'b1);
                else        push_exp(1'b0, 32'd1001 + k, 1'b0, 1'b1);
                if (k > 0) check("t3_interval", cyc - last, 32'd3);
                last = cyc;
                @(posedge clock); #1;
                if (exp_id) drive_ops(1'b1, 32'd50, k + 2, 1'b1);
                else        drive_ops(1'b0, 32'd1000 + k + 2, 32'd1, 1'b0);
                k++;
            end
        end
        check("t3_ops_done", k, 32'd20);
        bus.req_valid_0 = 0;
        bus.req_valid_1 = 0;
        wait_drain();

`ifdef ADD_ARB_STATS_EN
        @(posedge clock); #1;
        reset = 1'b1;
        #1;
        check("t6_clear_gc0", gc0, 32'd0);
        check("t6_clear_gc1", gc1, 32'd0);
        @(posedge clock); #1;
        reset = 1'b0;
        do_req(1'b0, 32'd1, 32'd1, 1'b0, 32'd2, 1'b0, 1'b0, w);
        do_req(1'b1, 32'd9, 32'd4, 1'b1, 32'd5, 1'b0, 1'b1, w);
        do_req(1'b0, 32'd2, 32'd2, 1'b0, 32'd4, 1'b0, 1'b0, w);
        do_req(1'b1, 32'd3, 32'd3, 1'b1, 32'd0, 1'b0, 1'b0, w);
        do_req(1'b0, 32'd7, 32'd1, 1'b0, 32'd8, 1'b0, 1'b1, w);
        wait_drain();
        check("t6_gc0", gc0, 32'd3);
        check("t6_gc1", gc1, 32'd2);
`endif

        repeat (2) @(negedge clock);
        check("sb_empty", sb.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
